// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: config sequencing, byte events, byte FIFO, counters
module uart_rx_ctrl #(
  parameter int         DEPTH      = 4,
  parameter int         CNT_W      = 8,
  parameter int         SETTLE     = 16,
  parameter bit         DROP_ERR   = 1'b1,
  parameter logic [1:0] RST_PARITY = 2'b00,
  parameter logic [1:0] RST_BAUD   = 2'b10
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_parity,
  input  logic [1:0]       cfg_baud,
  output logic             cfg_busy,
  output logic [1:0]       parity_type,
  output logic [1:0]       baud_rate,
  input  logic             rx_active,
  input  logic             rx_done,
  input  logic [2:0]       rx_error,
  input  logic [7:0]       rx_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic [2:0]       m_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             ovf_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [AW:0]      PTR_ONE     = (AW + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_APPLY, ST_SETTLE} state_t;

  state_t           state_q;
  logic             pend_q;
  logic [1:0]       pend_parity_q, pend_baud_q;
  logic [1:0]       parity_q, baud_q;
  logic [SW-1:0]    settle_q;
  logic             active_s1_q, active_s2_q;
  logic             done_s1_q, done_s2_q, done_s3_q;
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [10:0]      mem_q [DEPTH];
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic             ovf_flag_q, ovf_flag_d;

  logic ev, accept, has_err, push, pop, full, empty, wr_en, overflow;
  logic [10:0] head;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      active_s1_q <= 1'b0;
      active_s2_q <= 1'b0;
      done_s1_q   <= 1'b0;
      done_s2_q   <= 1'b0;
      done_s3_q   <= 1'b0;
    end else begin
      active_s1_q <= rx_active;
      active_s2_q <= active_s1_q;
      done_s1_q   <= rx_done;
      done_s2_q   <= done_s1_q;
      done_s3_q   <= done_s2_q;
    end
  end

  // Reconfiguration only happens with the receiver idle; BUSY exits straight to APPLY.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      pend_q        <= 1'b0;
      pend_parity_q <= RST_PARITY;
      pend_baud_q   <= RST_BAUD;
      parity_q      <= RST_PARITY;
      baud_q        <= RST_BAUD;
      settle_q      <= '0;
    end else begin
      if (cfg_wr) begin
        pend_q        <= 1'b1;
        pend_parity_q <= cfg_parity;
        pend_baud_q   <= cfg_baud;
      end
      case (state_q)
        ST_IDLE: begin
          if (active_s2_q)  state_q <= ST_BUSY;
          else if (pend_q)  state_q <= ST_APPLY;
        end
        ST_BUSY: begin
          if (!active_s2_q) state_q <= pend_q ? ST_APPLY : ST_IDLE;
        end
        ST_APPLY: begin
          parity_q <= pend_parity_q;
          baud_q   <= pend_baud_q;
          if (!cfg_wr) pend_q <= 1'b0;
          settle_q <= '0;
          state_q  <= ST_SETTLE;
        end
        default: begin
          if (settle_q == SETTLE_LAST) state_q <= ST_IDLE;
          else                         settle_q <= settle_q + SETTLE_ONE;
        end
      endcase
    end
  end

  assign cfg_busy    = pend_q | (state_q == ST_APPLY) | (state_q == ST_SETTLE);
  assign parity_type = parity_q;
  assign baud_rate   = baud_q;

  assign ev       = done_s2_q & ~done_s3_q;
  assign accept   = ev & ((state_q == ST_IDLE) | (state_q == ST_BUSY));
  assign has_err  = |rx_error;
  assign push     = accept & ~(DROP_ERR & has_err);
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop      = ~empty & m_ready;
  assign wr_en    = push & (~full | pop);
  assign overflow = push & full & ~pop;

  always_comb begin
    wr_d = wr_en ? wr_q + PTR_ONE : wr_q;
    rd_d = pop   ? rd_q + PTR_ONE : rd_q;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {rx_error, rx_data};
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  assign head    = mem_q[rd_q[AW-1:0]];
  assign m_valid = ~empty;
  assign m_data  = m_valid ? head[7:0] : 8'h00;
  assign m_err   = (m_valid && !DROP_ERR) ? head[10:8] : 3'b000;

  // Clear takes priority over any same-cycle increment.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (clr_cnt) begin
      err_cnt_d  = '0;
      ovf_cnt_d  = '0;
      ovf_flag_d = 1'b0;
    end else begin
      if (accept && has_err && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
      if (overflow) begin
        if (ovf_cnt_q != CNT_MAX) ovf_cnt_d = ovf_cnt_q + CNT_ONE;
        ovf_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      err_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
      ovf_flag_q <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;
  assign ovf_flag = ovf_flag_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized self-checking bench for uart_rx_ctrl, DROP_ERR=1 and DROP_ERR=0 side by side
module tb_uart_rx_ctrl;

  logic       clock = 1'b0;
  logic       rst, cfg_wr, rx_active, rx_done, m_ready, clr_cnt;
  logic [1:0] cfg_parity, cfg_baud;
  logic [2:0] rx_error;
  logic [7:0] rx_data;

  logic       cfg_busy1, m_valid1, ovf_flag1, cfg_busy0, m_valid0, ovf_flag0;
  logic [1:0] parity1, baud1, parity0, baud0;
  logic [7:0] m_data1, m_data0, err_cnt1, ovf_cnt1, err_cnt0, ovf_cnt0;
  logic [2:0] m_err1, m_err0;

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] q1[$];
  logic [10:0] q0[$];
  logic [7:0]  me1, mo1, me0, mo0;
  logic        mf1, mf0;

  always #5 clock = ~clock;

  uart_rx_ctrl dut1 (
    .clock(clock), .rst(rst), .cfg_wr(cfg_wr), .cfg_parity(cfg_parity), .cfg_baud(cfg_baud),
    .cfg_busy(cfg_busy1), .parity_type(parity1), .baud_rate(baud1), .rx_active(rx_active),
    .rx_done(rx_done), .rx_error(rx_error), .rx_data(rx_data), .m_valid(m_valid1),
    .m_ready(m_ready), .m_data(m_data1), .m_err(m_err1), .clr_cnt(clr_cnt),
    .err_cnt(err_cnt1), .ovf_cnt(ovf_cnt1), .ovf_flag(ovf_flag1)
  );

  uart_rx_ctrl #(.DROP_ERR(1'b0)) dut0 (
    .clock(clock), .rst(rst), .cfg_wr(cfg_wr), .cfg_parity(cfg_parity), .cfg_baud(cfg_baud),
    .cfg_busy(cfg_busy0), .parity_type(parity0), .baud_rate(baud0), .rx_active(rx_active),
    .rx_done(rx_done), .rx_error(rx_error), .rx_data(rx_data), .m_valid(m_valid0),
    .m_ready(m_ready), .m_data(m_data0), .m_err(m_err0), .clr_cnt(clr_cnt),
    .err_cnt(err_cnt0), .ovf_cnt(ovf_cnt0), .ovf_flag(ovf_flag0)
  );

  // Frame-level reference: a 4-entry byte queue plus saturating counters.
  task automatic model_frame(input logic [7:0] d, input logic [2:0] e);
    if (e != 3'b000) begin
      if (me1 != 8'd255) me1 = me1 + 8'd1;
      if (me0 != 8'd255) me0 = me0 + 8'd1;
    end
    if (e == 3'b000) begin
      if (q1.size() < 4) q1.push_back({3'b000, d});
      else begin if (mo1 != 8'd255) mo1 = mo1 + 8'd1; mf1 = 1'b1; end
    end
    if (q0.size() < 4) q0.push_back({e, d});
    else begin if (mo0 != 8'd255) mo0 = mo0 + 8'd1; mf0 = 1'b1; end
  endtask

  task automatic model_reset_counters();
    me1 = 0; mo1 = 0; mf1 = 0; me0 = 0; mo0 = 0; mf0 = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [2:0] e);
    @(negedge clock);
    rx_active = 1'b1;
    repeat (2) @(negedge clock);
    rx_data = d; rx_error = e; rx_done = 1'b1;
    repeat (3) @(negedge clock);
    rx_done = 1'b0; rx_active = 1'b0;
    repeat (4) @(negedge clock);
    model_frame(d, e);
  endtask

  task automatic do_clear();
    @(negedge clock);
    clr_cnt = 1'b1;
    @(negedge clock);
    clr_cnt = 1'b0;
    model_reset_counters();
  endtask

  task automatic drain_fifo(input string name);
    logic exp_v;
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_v = (q1.size() > 0);
      vectors++;
      if (m_valid1 !== exp_v || (exp_v && {m_err1, m_data1} !== q1[0])) begin
        miscompares++;
        $display("FAIL %s dut1 cycle %0d: got v=%b err=%b data=%h, exp v=%b head=%h", name, c, m_valid1, m_err1, m_data1, exp_v, exp_v ? q1[0] : 11'h0);
      end
      if (exp_v) void'(q1.pop_front());
      exp_v = (q0.size() > 0);
      vectors++;
      if (m_valid0 !== exp_v || (exp_v && {m_err0, m_data0} !== q0[0])) begin
        miscompares++;
        $display("FAIL %s dut0 cycle %0d: got v=%b err=%b data=%h, exp v=%b head=%h", name, c, m_valid0, m_err0, m_data0, exp_v, exp_v ? q0[0] : 11'h0);
      end
      if (exp_v) void'(q0.pop_front());
      @(negedge clock);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    vectors++;
    if ({m_valid1, m_data1, m_err1, err_cnt1, ovf_cnt1, ovf_flag1, cfg_busy1, parity1, baud1} !== {1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10}) begin
      miscompares++;
      $display("FAIL reset dut1: got v=%b d=%h e=%b ec=%0d oc=%0d of=%b busy=%b par=%b baud=%b, exp all zero, baud=10", m_valid1, m_data1, m_err1, err_cnt1, ovf_cnt1, ovf_flag1, cfg_busy1, parity1, baud1);
    end
    vectors++;
    if ({m_valid0, err_cnt0, ovf_cnt0, ovf_flag0, cfg_busy0, parity0, baud0} !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10}) begin
      miscompares++;
      $display("FAIL reset dut0: got v=%b ec=%0d oc=%0d of=%b busy=%b par=%b baud=%b, exp all zero, baud=10", m_valid0, err_cnt0, ovf_cnt0, ovf_flag0, cfg_busy0, parity0, baud0);
    end
  endtask

  task automatic test_latency();
    m_ready = 1'b1;
    rx_active = 1'b1;
    repeat (3) @(negedge clock);
    rx_data = 8'hA5; rx_error = 3'b000; rx_done = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    vectors++;
    if (m_valid1 !== 1'b0) begin miscompares++; $display("FAIL latency k+1 m_valid: got %b exp 0", m_valid1); end
    @(posedge clock); #1;
    vectors++;
    if ({m_valid1, m_data1, m_err1} !== {1'b1, 8'hA5, 3'b000}) begin
      miscompares++; $display("FAIL latency k+2 dut1: got v=%b d=%h e=%b exp v=1 d=a5 e=000", m_valid1, m_data1, m_err1);
    end
    vectors++;
    if ({m_valid0, m_data0, m_err0} !== {1'b1, 8'hA5, 3'b000}) begin
      miscompares++; $display("FAIL latency k+2 dut0: got v=%b d=%h e=%b exp v=1 d=a5 e=000", m_valid0, m_data0, m_err0);
    end
    @(posedge clock); #1;
    vectors++;
    if ({m_valid1, m_valid0} !== 2'b00) begin miscompares++; $display("FAIL latency pulse width: got %b%b exp 00", m_valid1, m_valid0); end
    @(negedge clock);
    rx_done = 1'b0; rx_active = 1'b0; m_ready = 1'b0;
    repeat (4) @(negedge clock);
    vectors++;
    if ({err_cnt1, err_cnt0} !== 16'h0000) begin miscompares++; $display("FAIL latency err_cnt: got %0d/%0d exp 0", err_cnt1, err_cnt0); end
  endtask

  task automatic test_error();
    send_frame(8'h3C, 3'b001);
    vectors++;
    if ({m_valid1, err_cnt1} !== {1'b0, 8'd1}) begin
      miscompares++; $display("FAIL error drop dut1: got v=%b ec=%0d exp v=0 ec=1", m_valid1, err_cnt1);
    end
    vectors++;
    if ({m_valid0, m_data0, m_err0, err_cnt0} !== {1'b1, 8'h3C, 3'b001, 8'd1}) begin
      miscompares++; $display("FAIL error keep dut0: got v=%b d=%h e=%b ec=%0d exp v=1 d=3c e=001 ec=1", m_valid0, m_data0, m_err0, err_cnt0);
    end
    drain_fifo("error_drain");
    do_clear();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 3'b000);
    vectors++;
    if ({ovf_cnt1, ovf_flag1, ovf_cnt0, ovf_flag0} !== {8'd2, 1'b1, 8'd2, 1'b1}) begin
      miscompares++; $display("FAIL overflow counters: got %0d/%b %0d/%b exp 2/1 2/1", ovf_cnt1, ovf_flag1, ovf_cnt0, ovf_flag0);
    end
    drain_fifo("overflow_order");
    do_clear();
    @(negedge clock);
    vectors++;
    if ({ovf_cnt1, ovf_flag1, ovf_cnt0, ovf_flag0} !== 18'h0) begin
      miscompares++; $display("FAIL overflow clear: got %0d/%b %0d/%b exp 0/0 0/0", ovf_cnt1, ovf_flag1, ovf_cnt0, ovf_flag0);
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] d;
    logic [2:0] e;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        e = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        send_frame(d, e);
      end
      vectors++;
      if ({err_cnt1, ovf_cnt1, ovf_flag1} !== {me1, mo1, mf1}) begin
        miscompares++; $display("FAIL random round %0d dut1 counters: got %0d/%0d/%b exp %0d/%0d/%b", r, err_cnt1, ovf_cnt1, ovf_flag1, me1, mo1, mf1);
      end
      vectors++;
      if ({err_cnt0, ovf_cnt0, ovf_flag0} !== {me0, mo0, mf0}) begin
        miscompares++; $display("FAIL random round %0d dut0 counters: got %0d/%0d/%b exp %0d/%0d/%b", r, err_cnt0, ovf_cnt0, ovf_flag0, me0, mo0, mf0);
      end
      drain_fifo("random_drain");
      if (r % 3 == 2) do_clear();
    end
    do_clear();
  endtask

  task automatic test_config();
    int n;
    @(negedge clock);
    rx_active = 1'b1;
    repeat (4) @(negedge clock);
    cfg_parity = 2'b00; cfg_baud = 2'b11; cfg_wr = 1'b1;
    @(negedge clock);
    cfg_wr = 1'b0;
    repeat (5) @(negedge clock);
    vectors++;
    if ({baud1, cfg_busy1, baud0, cfg_busy0} !== {2'b10, 1'b1, 2'b10, 1'b1}) begin
      miscompares++; $display("FAIL config held while active: got baud=%b busy=%b exp baud=10 busy=1", baud1, cfg_busy1);
    end
    rx_active = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    vectors++;
    if (baud1 !== 2'b10) begin miscompares++; $display("FAIL config edge+2 baud: got %b exp 10", baud1); end
    @(posedge clock); #1;
    vectors++;
    if (baud1 !== 2'b10) begin miscompares++; $display("FAIL config edge+3 baud: got %b exp 10", baud1); end
    @(posedge clock); #1;
    vectors++;
    if ({baud1, cfg_busy1, baud0} !== {2'b11, 1'b1, 2'b11}) begin
      miscompares++; $display("FAIL config applied: got baud=%b busy=%b exp baud=11 busy=1", baud1, cfg_busy1);
    end
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (!cfg_busy1) begin n = c; break; end
      if (c == 1) begin rx_data = 8'h77; rx_error = 3'b001; rx_done = 1'b1; end
      if (c == 6) rx_done = 1'b0;
    end
    vectors++;
    if (n != 16) begin miscompares++; $display("FAIL config settle length: got %0d cycles exp 16", n); end
    rx_error = 3'b000;
    repeat (4) @(negedge clock);
    vectors++;
    if ({m_valid1, m_valid0, err_cnt1, err_cnt0} !== {2'b00, me1, me0}) begin
      miscompares++; $display("FAIL config event during settle: got v=%b%b ec=%0d/%0d exp v=00 ec=%0d/%0d", m_valid1, m_valid0, err_cnt1, err_cnt0, me1, me0);
    end
  endtask

  task automatic test_double_cfg();
    int changes;
    bit saw01;
    bit done_ok;
    logic [1:0] prev;
    @(negedge clock);
    rx_active = 1'b1;
    repeat (4) @(negedge clock);
    cfg_parity = 2'b01; cfg_baud = 2'b11; cfg_wr = 1'b1;
    @(negedge clock);
    cfg_parity = 2'b10;
    @(negedge clock);
    cfg_wr = 1'b0;
    repeat (3) @(negedge clock);
    rx_active = 1'b0;
    changes = 0; saw01 = 0; done_ok = 0; prev = parity1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (parity1 !== prev) changes++;
      if (parity1 === 2'b01) saw01 = 1;
      prev = parity1;
      if (!cfg_busy1) begin done_ok = 1; break; end
    end
    vectors++;
    if (!done_ok) begin miscompares++; $display("FAIL double_cfg timeout: cfg_busy still %b after 40 cycles", cfg_busy1); end
    vectors++;
    if ({parity1, parity0, baud1} !== {2'b10, 2'b10, 2'b11} || changes != 1 || saw01) begin
      miscompares++; $display("FAIL double_cfg last wins: got par=%b/%b baud=%b changes=%0d saw01=%0d exp par=10 changes=1 saw01=0", parity1, parity0, baud1, changes, saw01);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) send_frame(8'hFF, 3'($urandom_range(1, 7)));
    vectors++;
    if ({err_cnt1, err_cnt0} !== {8'd255, 8'd255} || {err_cnt1, err_cnt0} !== {me1, me0}) begin
      miscompares++; $display("FAIL saturation err_cnt: got %0d/%0d exp 255/255", err_cnt1, err_cnt0);
    end
    vectors++;
    if ({ovf_cnt0, ovf_flag0, m_valid0, m_valid1} !== {mo0, mf0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL saturation dut0 overflow: got oc=%0d of=%b v=%b/%b exp oc=%0d of=%b v=1/0", ovf_cnt0, ovf_flag0, m_valid0, m_valid1, mo0, mf0);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    rx_active = 1'b1; rx_data = 8'h5A; rx_done = 1'b1;
    @(posedge clock);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({m_valid1, m_data1, m_err1, err_cnt1, ovf_cnt1, ovf_flag1, cfg_busy1, parity1, baud1} !== {1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10}) begin
      miscompares++;
      $display("FAIL async_reset dut1: got v=%b d=%h e=%b ec=%0d oc=%0d of=%b busy=%b par=%b baud=%b", m_valid1, m_data1, m_err1, err_cnt1, ovf_cnt1, ovf_flag1, cfg_busy1, parity1, baud1);
    end
    vectors++;
    if ({m_valid0, m_data0, m_err0, err_cnt0, ovf_cnt0, ovf_flag0, cfg_busy0, parity0, baud0} !== {1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 2'b10}) begin
      miscompares++;
      $display("FAIL async_reset dut0: got v=%b d=%h e=%b ec=%0d oc=%0d of=%b busy=%b par=%b baud=%b", m_valid0, m_data0, m_err0, err_cnt0, ovf_cnt0, ovf_flag0, cfg_busy0, parity0, baud0);
    end
    rx_active = 1'b0; rx_done = 1'b0;
    q1.delete(); q0.delete(); model_reset_counters();
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    rst = 1'b0; cfg_wr = 1'b0; cfg_parity = 2'b00; cfg_baud = 2'b00;
    rx_active = 1'b0; rx_done = 1'b0; rx_error = 3'b000; rx_data = 8'h00;
    m_ready = 1'b0; clr_cnt = 1'b0;
    model_reset_counters();
    test_reset();
    test_latency();
    test_error();
    test_overflow();
    test_random();
    test_config();
    test_double_cfg();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget after %0d vectors", vectors);
    $fatal(1);
  end

endmodule
